// File: rtl/lif_tdm_scheduler.sv
//------------------------------------------------------------------------------
// Module      : lif_tdm_scheduler
// Description : Time-division LIF neuron scheduler sharing one update datapath
//               across NUM_NEURONS virtual neurons, with a valid/ready spike
//               output. Optional statistics enabled by LIF_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lif_tdm_scheduler #(
    parameter int                          NUM_NEURONS  = 8,
    parameter int                          DATA_WIDTH   = 16,
    parameter int                          WEIGHT_WIDTH = 8,
    parameter logic signed [DATA_WIDTH-1:0] THRESHOLD   = 16'h0100,
    parameter int                          LEAK_SHIFT   = 4,
    parameter logic signed [DATA_WIDTH-1:0] V_RESET     = 16'h0000,
    parameter int                          REFRACTORY   = 4,
    localparam int                         c_IDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    tick,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [c_IDX_W-1:0]      in_idx,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    output logic                    spike_valid,
    input  logic                    spike_ready,
    output logic [c_IDX_W-1:0]      spike_idx,
    output logic                    busy,
    output logic                    done,
    input  logic [c_IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_vmem,
    output logic [15:0]             stat_spikes,
    output logic                    stat_overrun
);

    localparam int c_REFR_W = (REFRACTORY < 1) ? 1 : $clog2(REFRACTORY + 1);
    // Two guard bits cover v - leak + acc without overflow before saturation.
    localparam int c_EXT_W  = DATA_WIDTH + 2;
    localparam logic signed [c_EXT_W-1:0] c_EXT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_EXT_W-1:0] c_EXT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_NEURONS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    function automatic logic signed [DATA_WIDTH-1:0] f_sat(input logic signed [c_EXT_W-1:0] x);
        if (x > c_EXT_MAX)      f_sat = c_EXT_MAX[DATA_WIDTH-1:0];
        else if (x < c_EXT_MIN) f_sat = c_EXT_MIN[DATA_WIDTH-1:0];
        else                    f_sat = x[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]                    r_state, w_state_nxt;
    logic [c_IDX_W-1:0]            r_ptr, w_ptr_nxt;
    logic signed [DATA_WIDTH-1:0]  r_v   [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0]  r_acc [NUM_NEURONS];
    logic [c_REFR_W-1:0]           r_refr[NUM_NEURONS];
    logic                          r_spike_valid;
    logic [c_IDX_W-1:0]            r_spike_idx;
    logic [DATA_WIDTH-1:0]         r_rd_vmem;

    logic signed [DATA_WIDTH-1:0]  w_v_cur, w_acc_cur, w_leak, w_v_nxt, w_acc_nxt;
    logic [c_REFR_W-1:0]           w_refr_cur;
    logic signed [c_EXT_W-1:0]     w_sum, w_acc_sum;
    logic                          w_accept, w_fire, w_update, w_stall, w_commit, w_spike_load;

    assign in_ready  = enable & (r_state == S_IDLE) & ~rst;
    assign w_accept  = in_valid & in_ready;
    assign w_acc_sum = c_EXT_W'(r_acc[in_idx]) + c_EXT_W'($signed(in_weight));
    assign w_acc_nxt = f_sat(w_acc_sum);

    assign w_v_cur    = r_v[r_ptr];
    assign w_acc_cur  = r_acc[r_ptr];
    assign w_refr_cur = r_refr[r_ptr];
    assign w_leak     = w_v_cur >>> LEAK_SHIFT;
    assign w_sum      = c_EXT_W'(w_v_cur) - c_EXT_W'(w_leak) + c_EXT_W'(w_acc_cur);
    assign w_v_nxt    = f_sat(w_sum);
    assign w_fire     = (w_refr_cur == '0) && (w_v_nxt >= THRESHOLD);

    // A due spike with an undrained output register holds the whole sweep.
    assign w_update     = (r_state == S_UPDATE) & enable;
    assign w_stall      = w_fire & r_spike_valid & ~spike_ready;
    assign w_commit     = w_update & ~w_stall;
    assign w_spike_load = w_commit & w_fire;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (tick && enable) begin
                    w_state_nxt = S_UPDATE;
                    w_ptr_nxt   = '0;
                end
            end
            S_UPDATE: begin
                if (w_commit) begin
                    w_ptr_nxt = r_ptr + c_IDX_W'(1);
                    if (r_ptr == c_LAST) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (enable) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i]    <= V_RESET;
                r_acc[i]  <= '0;
                r_refr[i] <= '0;
            end
        end else begin
            if (w_accept) r_acc[in_idx] <= w_acc_nxt;
            if (w_commit) begin
                r_acc[r_ptr] <= '0;
                if (w_refr_cur != '0) begin
                    r_refr[r_ptr] <= w_refr_cur - c_REFR_W'(1);
                    r_v[r_ptr]    <= V_RESET;
                end else if (w_fire) begin
                    r_refr[r_ptr] <= c_REFR_W'(REFRACTORY);
                    r_v[r_ptr]    <= V_RESET;
                end else begin
                    r_v[r_ptr]    <= w_v_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spike_valid <= 1'b0;
            r_spike_idx   <= '0;
            r_rd_vmem     <= '0;
        end else begin
            if (w_spike_load) begin
                r_spike_valid <= 1'b1;
                r_spike_idx   <= r_ptr;
            end else if (spike_ready) begin
                r_spike_valid <= 1'b0;
            end
            r_rd_vmem <= r_v[rd_idx];
        end
    end

    assign spike_valid = r_spike_valid;
    assign spike_idx   = r_spike_idx;
    assign busy        = (r_state == S_UPDATE) | (r_state == S_DONE);
    assign done        = (r_state == S_DONE);
    assign rd_vmem     = r_rd_vmem;

`ifdef LIF_SCHED_STATS_EN
    logic [15:0] r_stat_spikes;
    logic        r_stat_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_spikes  <= '0;
            r_stat_overrun <= 1'b0;
        end else begin
            if (w_spike_load && (r_stat_spikes != 16'hFFFF)) r_stat_spikes <= r_stat_spikes + 16'd1;
            if (tick && (busy || !enable)) r_stat_overrun <= 1'b1;
        end
    end

    assign stat_spikes  = r_stat_spikes;
    assign stat_overrun = r_stat_overrun;
`else
    assign stat_spikes  = '0;
    assign stat_overrun = 1'b0;
`endif

endmodule

`default_nettype wire
